// File: rtl/risc_pkg.sv
// Shared opcodes, instruction field positions and decoded-control types
// used by the pipelined RISC core and its sub-modules.
package risc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_ORI   = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_OR  = 6'd3;
  localparam logic [5:0] FN_XOR = 6'd4;
  localparam logic [5:0] FN_SLL = 6'd5;
  localparam logic [5:0] FN_SRL = 6'd6;

  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5,  FN_LO = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL
  } alu_op_t;

  typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT} imm_sel_t;

  typedef struct packed {
    alu_op_t  alu_op;
    logic     we;
    logic [4:0] dst;
    logic     is_branch;
    logic     branch_ne;
    logic     is_halt;
    imm_sel_t imm_sel;
  } ctrl_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/risc_pipe_core_regfile.sv
// 32-entry register file: two combinational read ports, one write port,
// same-cycle write-through to the readers and r0 hardwired to zero.
module risc_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [32];

  // Storage update; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the value being written this cycle.
  always_comb begin
    if (ra1 == 5'd0) rd1 = '0;
    else if (we && (wa == ra1)) rd1 = wd;
    else rd1 = regs[ra1];
    if (ra2 == 5'd0) rd2 = '0;
    else if (we && (wa == ra2)) rd2 = wd;
    else rd2 = regs[ra2];
  end

endmodule

// File: rtl/risc_pipe_core.sv
// Four-stage (F/D/E/W) pipelined RISC core with RAW stall or forwarding,
// branch resolution in E with flush, HALT, and a registered retire port.
module risc_pipe_core
  import risc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int FORWARD = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            retire_valid,
  output logic [PC_W-1:0] retire_pc,
  output logic            retire_we,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            halted,
  output logic [31:0]     bubble_cnt
);

  logic [PC_W-1:0] pc, ifid_pc, idex_pc, e_target;
  logic            halt_seen, ifid_valid, idex_valid;
  logic [31:0]     ifid_instr;
  ctrl_t           d_ctrl, idex_ctrl;
  logic            d_use_rs, d_use_rt, d_wr, raw, stall, d_halt, e_taken;
  logic [4:0]      d_rs, d_rt, idex_rs, idex_rt, idex_shamt;
  logic [15:0]     idex_imm;
  logic [XLEN-1:0] rf_a, rf_b, idex_a, idex_b, e_a, e_b, e_src_b, e_result;

  assign imem_addr = pc;
  assign d_rs = ifid_instr[RS_HI:RS_LO];
  assign d_rt = ifid_instr[RT_HI:RT_LO];

  risc_regfile #(.XLEN(XLEN)) u_regfile (
    .clk(clk), .rst(rst), .ra1(d_rs), .ra2(d_rt), .rd1(rf_a), .rd2(rf_b),
    .we(retire_we), .wa(retire_rd), .wd(retire_data)
  );

  // Decode of the IF/ID instruction into control plus source-use flags.
  always_comb begin
    d_ctrl   = '0;
    d_use_rs = 1'b0;
    d_use_rt = 1'b0;
    d_wr     = 1'b0;
    case (ifid_instr[OP_HI:OP_LO])
      OP_RTYPE: begin
        d_ctrl.dst = ifid_instr[RD_HI:RD_LO];
        d_use_rs = 1'b1;
        d_use_rt = 1'b1;
        d_wr     = 1'b1;
        case (ifid_instr[FN_HI:FN_LO])
          FN_ADD:  d_ctrl.alu_op = ALU_ADD;
          FN_SUB:  d_ctrl.alu_op = ALU_SUB;
          FN_AND:  d_ctrl.alu_op = ALU_AND;
          FN_OR:   d_ctrl.alu_op = ALU_OR;
          FN_XOR:  d_ctrl.alu_op = ALU_XOR;
          FN_SLL:  begin d_ctrl.alu_op = ALU_SLL; d_use_rs = 1'b0; end
          FN_SRL:  begin d_ctrl.alu_op = ALU_SRL; d_use_rs = 1'b0; end
          default: begin d_use_rs = 1'b0; d_use_rt = 1'b0; d_wr = 1'b0; end
        endcase
      end
      OP_ADDI: begin
        d_ctrl.dst = d_rt; d_ctrl.imm_sel = IMM_SEXT; d_use_rs = 1'b1; d_wr = 1'b1;
      end
      OP_ORI: begin
        d_ctrl.dst = d_rt; d_ctrl.imm_sel = IMM_ZEXT; d_ctrl.alu_op = ALU_OR;
        d_use_rs = 1'b1; d_wr = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d_ctrl.is_branch = 1'b1;
        d_ctrl.branch_ne = (ifid_instr[OP_HI:OP_LO] == OP_BNE);
        d_use_rs = 1'b1;
        d_use_rt = 1'b1;
      end
      OP_HALT: d_ctrl.is_halt = 1'b1;
      default: d_wr = 1'b0;
    endcase
    d_ctrl.we = d_wr && (d_ctrl.dst != 5'd0);
  end

  // Only a distance-1 dependence stalls; write-through covers distance 2.
  assign raw = ifid_valid && idex_valid && idex_ctrl.we &&
               ((d_use_rs && (d_rs == idex_ctrl.dst)) || (d_use_rt && (d_rt == idex_ctrl.dst)));
  assign stall  = (FORWARD == 0) && raw && !e_taken;
  assign d_halt = ifid_valid && d_ctrl.is_halt;

  // Execute: operand forwarding, ALU and branch resolution.
  always_comb begin
    e_a = idex_a;
    e_b = idex_b;
    if ((FORWARD != 0) && retire_we && (retire_rd == idex_rs)) e_a = retire_data;
    else e_a = idex_a;
    if ((FORWARD != 0) && retire_we && (retire_rd == idex_rt)) e_b = retire_data;
    else e_b = idex_b;
    case (idex_ctrl.imm_sel)
      IMM_SEXT: e_src_b = XLEN'($signed(idex_imm));
      IMM_ZEXT: e_src_b = XLEN'(idex_imm);
      default:  e_src_b = e_b;
    endcase
    case (idex_ctrl.alu_op)
      ALU_ADD: e_result = e_a + e_src_b;
      ALU_SUB: e_result = e_a - e_src_b;
      ALU_AND: e_result = e_a & e_src_b;
      ALU_OR:  e_result = e_a | e_src_b;
      ALU_XOR: e_result = e_a ^ e_src_b;
      ALU_SLL: e_result = e_b << idex_shamt;
      ALU_SRL: e_result = e_b >> idex_shamt;
      default: e_result = '0;
    endcase
    e_taken  = idex_valid && idex_ctrl.is_branch && ((e_a == e_b) != idex_ctrl.branch_ne);
    e_target = idex_pc + PC_W'(3'd4) + PC_W'($signed({idex_imm, 2'b00}));
  end

  // Fetch: PC and IF/ID; a flush beats a stall, and a decoded HALT stops fetch for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      halt_seen  <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= 32'd0;
    end else if (e_taken) begin
      pc         <= e_target;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      ifid_valid <= ifid_valid;
    end else if (halt_seen || d_halt) begin
      halt_seen  <= 1'b1;
      ifid_valid <= 1'b0;
    end else begin
      pc         <= pc + PC_W'(3'd4);
      ifid_valid <= 1'b1;
      ifid_pc    <= pc;
      ifid_instr <= imem_rdata;
    end
  end

  // ID/EX register; flush and stall both leave a bubble here.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid <= 1'b0;
      idex_pc    <= '0;
      idex_ctrl  <= '0;
      idex_rs    <= 5'd0;
      idex_rt    <= 5'd0;
      idex_shamt <= 5'd0;
      idex_imm   <= 16'd0;
      idex_a     <= '0;
      idex_b     <= '0;
    end else begin
      idex_valid <= ifid_valid && !e_taken && !stall;
      idex_pc    <= ifid_pc;
      idex_ctrl  <= d_ctrl;
      idex_rs    <= d_rs;
      idex_rt    <= d_rt;
      idex_shamt <= ifid_instr[SH_HI:SH_LO];
      idex_imm   <= ifid_instr[IMM_HI:IMM_LO];
      idex_a     <= rf_a;
      idex_b     <= rf_b;
    end
  end

  // EX/WB register, which is also the retire port and the regfile write source.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_we    <= 1'b0;
      retire_rd    <= 5'd0;
      retire_data  <= '0;
      halted       <= 1'b0;
    end else begin
      retire_valid <= idex_valid;
      retire_pc    <= idex_valid ? idex_pc : '0;
      retire_we    <= idex_valid && idex_ctrl.we;
      retire_rd    <= idex_valid ? idex_ctrl.dst : 5'd0;
      retire_data  <= idex_valid ? e_result : '0;
      halted       <= halted || (idex_valid && idex_ctrl.is_halt);
    end
  end

  // Bubble accounting: two per taken branch, one per RAW stall.
  always_ff @(posedge clk) begin
    if (rst) bubble_cnt <= 32'd0;
    else if (e_taken) bubble_cnt <= sat_add(bubble_cnt, 2'd2);
    else if (stall) bubble_cnt <= sat_add(bubble_cnt, 2'd1);
    else bubble_cnt <= bubble_cnt;
  end

endmodule

// File: tb/tb_risc_pipe_core.sv
// Directed bench for risc_pipe_core: one stall-based (FORWARD=0) and one
// forwarding (FORWARD=1) instance run the same hand-encoded programs.
module tb_risc_pipe_core;

  typedef struct {
    logic [15:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
    logic        hlt;
  } ret_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] imem [0:63];
  logic [15:0] addr0, addr1, rpc0, rpc1;
  logic [31:0] rdata0, rdata1, rdat0, rdat1, bcnt0, bcnt1;
  logic        rv0, rv1, rwe0, rwe1, hlt0, hlt1;
  logic [4:0]  rrd0, rrd1;
  ret_t log0[$];
  ret_t log1[$];
  int cyc = 0;
  int base = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdata0 = imem[addr0[7:2]];
  assign rdata1 = imem[addr1[7:2]];

  risc_pipe_core #(.XLEN(32), .PC_W(16), .RESET_PC(16'h0000), .FORWARD(0)) dut0 (
    .clk(clk), .rst(rst), .imem_addr(addr0), .imem_rdata(rdata0),
    .retire_valid(rv0), .retire_pc(rpc0), .retire_we(rwe0), .retire_rd(rrd0),
    .retire_data(rdat0), .halted(hlt0), .bubble_cnt(bcnt0)
  );

  risc_pipe_core #(.XLEN(32), .PC_W(16), .RESET_PC(16'h0000), .FORWARD(1)) dut1 (
    .clk(clk), .rst(rst), .imem_addr(addr1), .imem_rdata(rdata1),
    .retire_valid(rv1), .retire_pc(rpc1), .retire_we(rwe1), .retire_rd(rrd1),
    .retire_data(rdat1), .halted(hlt1), .bubble_cnt(bcnt1)
  );

  // Retire monitor for both cores, sampled on the falling edge.
  always @(negedge clk) begin
    if (rv0) log0.push_back('{pc: rpc0, we: rwe0, rd: rrd0, data: rdat0, cyc: cyc, hlt: hlt0});
    if (rv1) log1.push_back('{pc: rpc1, we: rwe1, rd: rrd1, data: rdat1, cyc: cyc, hlt: hlt1});
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = cyc;
    log0.delete();
    log1.delete();
  endtask

  task automatic test_reset();
    clear_imem();
    do_reset();
    tests++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin fails++; $display("FAIL reset_rv got %b/%b want 0", rv0, rv1); end
    tests++; if (addr0 !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h want 0000", addr0); end
    tests++; if (bcnt0 !== 32'd0) begin fails++; $display("FAIL reset_bcnt got %0d want 0", bcnt0); end
    tests++; if (hlt0 !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", hlt0); end
  endtask

  task automatic test_raw();
    clear_imem();
    imem[0] = enc_i(6'd1, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'd1, 5'd1, 5'd2, 16'd3);
    do_reset();
    run(10);
    tests++;
    if (log0.size() < 2 || log1.size() < 2) begin
      fails++; $display("FAIL raw_count got %0d/%0d want >=2", log0.size(), log1.size());
    end else begin
      tests++; if (log0[0].cyc - base !== 3) begin fails++; $display("FAIL raw_latency got %0d want 3", log0[0].cyc - base); end
      tests++; if (log0[0].rd !== 5'd1 || log0[0].data !== 32'd5) begin fails++; $display("FAIL raw_r1 got r%0d=%0d want r1=5", log0[0].rd, log0[0].data); end
      tests++; if (log0[1].rd !== 5'd2 || log0[1].data !== 32'd8) begin fails++; $display("FAIL raw_f0_r2 got r%0d=%0d want r2=8", log0[1].rd, log0[1].data); end
      tests++; if (log0[1].cyc - log0[0].cyc !== 2) begin fails++; $display("FAIL raw_f0_gap got %0d want 2", log0[1].cyc - log0[0].cyc); end
      tests++; if (log1[1].rd !== 5'd2 || log1[1].data !== 32'd8) begin fails++; $display("FAIL raw_f1_r2 got r%0d=%0d want r2=8", log1[1].rd, log1[1].data); end
      tests++; if (log1[1].cyc - log1[0].cyc !== 1) begin fails++; $display("FAIL raw_f1_gap got %0d want 1", log1[1].cyc - log1[0].cyc); end
    end
    tests++; if (bcnt0 !== 32'd1) begin fails++; $display("FAIL raw_f0_bcnt got %0d want 1", bcnt0); end
    tests++; if (bcnt1 !== 32'd0) begin fails++; $display("FAIL raw_f1_bcnt got %0d want 0", bcnt1); end
  endtask

  task automatic test_rtype();
    logic [4:0]  exp_rd [11];
    logic [31:0] exp_d  [11];
    ret_t lg[$];
    exp_rd = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd0};
    exp_d  = '{32'hFF, 32'hE1, 32'h0, 32'hFF, 32'hF0, 32'h0F, 32'hFF, 32'h8000,
               32'hFFFF_FFFF, 32'h1, 32'h0};
    clear_imem();
    imem[0]  = enc_i(6'd1, 5'd0, 5'd1, 16'h00F0);
    imem[1]  = enc_i(6'd1, 5'd0, 5'd2, 16'h000F);
    imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'd0);
    imem[3]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'd1);
    imem[4]  = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'd2);
    imem[5]  = enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'd4);
    imem[6]  = enc_r(5'd0, 5'd2, 5'd7, 5'd4, 6'd5);
    imem[7]  = enc_r(5'd0, 5'd1, 5'd8, 5'd4, 6'd6);
    imem[8]  = enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'd3);
    imem[9]  = enc_i(6'd2, 5'd0, 5'd10, 16'h8000);
    imem[10] = enc_i(6'd1, 5'd0, 5'd11, 16'hFFFF);
    imem[11] = enc_r(5'd0, 5'd11, 5'd12, 5'd0, 6'd1);
    imem[12] = enc_i(6'd3, 5'd0, 5'd13, 16'd5);
    do_reset();
    run(24);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) lg = log0; else lg = log1;
      tests++;
      if (lg.size() < 13) begin
        fails++; $display("FAIL rtype_count dut%0d got %0d want >=13", k, lg.size());
      end else begin
        for (int i = 0; i < 11; i++) begin
          tests++;
          if (lg[i+2].rd !== exp_rd[i] || (exp_rd[i] != 5'd0 && lg[i+2].data !== exp_d[i]) ||
              lg[i+2].we !== (exp_rd[i] != 5'd0)) begin
            fails++;
            $display("FAIL rtype_%0d dut%0d got r%0d=%h we=%b want r%0d=%h", i, k,
                     lg[i+2].rd, lg[i+2].data, lg[i+2].we, exp_rd[i], exp_d[i]);
          end
        end
      end
    end
    tests++; if (bcnt0 !== 32'd2) begin fails++; $display("FAIL rtype_f0_bcnt got %0d want 2", bcnt0); end
    tests++; if (bcnt1 !== 32'd0) begin fails++; $display("FAIL rtype_f1_bcnt got %0d want 0", bcnt1); end
  endtask

  task automatic test_branch(input logic [5:0] op);
    bit seen_shadow;
    clear_imem();
    imem[0] = enc_i(6'd1, 5'd0, 5'd1, 16'd1);
    imem[4] = enc_i(op, 5'd0, 5'd0, 16'd2);
    imem[5] = enc_i(6'd1, 5'd0, 5'd5, 16'h55);
    imem[6] = enc_i(6'd1, 5'd0, 5'd6, 16'h66);
    imem[7] = enc_i(6'd1, 5'd0, 5'd7, 16'h77);
    do_reset();
    run(14);
    tests++;
    if (log0.size() < 7) begin
      fails++; $display("FAIL br%0d_count got %0d want >=7", op, log0.size());
    end else if (op == 6'd4) begin
      seen_shadow = 1'b0;
      foreach (log0[i]) if (log0[i].pc == 16'h14 || log0[i].pc == 16'h18) seen_shadow = 1'b1;
      tests++; if (log0[4].pc !== 16'h10) begin fails++; $display("FAIL beq_pc4 got %h want 0010", log0[4].pc); end
      tests++; if (log0[5].pc !== 16'h1C || log0[5].data !== 32'h77) begin fails++; $display("FAIL beq_target got %h/%h want 001c/77", log0[5].pc, log0[5].data); end
      tests++; if (seen_shadow) begin fails++; $display("FAIL beq_shadow got retire of 0x14/0x18 want none"); end
      tests++; if (bcnt0 !== 32'd2 || bcnt1 !== 32'd2) begin fails++; $display("FAIL beq_bcnt got %0d/%0d want 2", bcnt0, bcnt1); end
    end else begin
      tests++; if (log0[5].pc !== 16'h14 || log0[5].data !== 32'h55) begin fails++; $display("FAIL bne_next got %h/%h want 0014/55", log0[5].pc, log0[5].data); end
      tests++; if (log0[6].pc !== 16'h18) begin fails++; $display("FAIL bne_next2 got %h want 0018", log0[6].pc); end
      tests++; if (bcnt0 !== 32'd0) begin fails++; $display("FAIL bne_bcnt got %0d want 0", bcnt0); end
    end
  endtask

  task automatic test_r0();
    clear_imem();
    imem[0] = enc_i(6'd1, 5'd0, 5'd0, 16'd7);
    imem[1] = enc_r(5'd0, 5'd0, 5'd3, 5'd0, 6'd0);
    do_reset();
    run(8);
    tests++;
    if (log1.size() < 2) begin
      fails++; $display("FAIL r0_count got %0d want >=2", log1.size());
    end else begin
      tests++; if (log1[0].we !== 1'b0) begin fails++; $display("FAIL r0_we got %b want 0", log1[0].we); end
      tests++; if (log1[1].rd !== 5'd3 || log1[1].we !== 1'b1 || log1[1].data !== 32'd0) begin
        fails++; $display("FAIL r0_read got r%0d=%h we=%b want r3=0 we=1", log1[1].rd, log1[1].data, log1[1].we);
      end
    end
  endtask

  task automatic test_halt();
    clear_imem();
    imem[0]  = enc_i(6'd4, 5'd0, 5'd0, 16'd15);
    imem[1]  = {6'd63, 26'd0};
    imem[16] = {6'd63, 26'd0};
    do_reset();
    run(12);
    tests++;
    if (log0.size() != 2 || log1.size() != 2) begin
      fails++; $display("FAIL halt_count got %0d/%0d want 2", log0.size(), log1.size());
    end else begin
      tests++; if (log0[0].pc !== 16'h0 || log0[0].hlt !== 1'b0) begin fails++; $display("FAIL halt_first got %h hlt=%b want 0000 hlt=0", log0[0].pc, log0[0].hlt); end
      tests++; if (log0[1].pc !== 16'h40 || log0[1].hlt !== 1'b1) begin fails++; $display("FAIL halt_retire got %h hlt=%b want 0040 hlt=1", log0[1].pc, log0[1].hlt); end
    end
    tests++; if (bcnt0 !== 32'd2) begin fails++; $display("FAIL halt_bcnt got %0d want 2", bcnt0); end
    run(10);
    tests++; if (log0.size() != 2 || log1.size() != 2) begin fails++; $display("FAIL halt_idle got %0d/%0d want 2", log0.size(), log1.size()); end
    tests++; if (hlt0 !== 1'b1 || hlt1 !== 1'b1) begin fails++; $display("FAIL halt_sticky got %b/%b want 1", hlt0, hlt1); end
    tests++; if (addr0 !== 16'h44) begin fails++; $display("FAIL halt_pc got %h want 0044", addr0); end
  endtask

  task automatic test_mid_reset();
    clear_imem();
    imem[0] = enc_i(6'd1, 5'd0, 5'd1, 16'd1);
    imem[1] = enc_i(6'd1, 5'd1, 5'd2, 16'd1);
    imem[2] = enc_i(6'd1, 5'd0, 5'd3, 16'd3);
    imem[3] = enc_i(6'd1, 5'd0, 5'd4, 16'd4);
    do_reset();
    run(3);
    tests++; if (bcnt0 !== 32'd1) begin fails++; $display("FAIL mrst_pre_bcnt got %0d want 1", bcnt0); end
    do_reset();
    tests++; if (rv0 !== 1'b0 || addr0 !== 16'h0 || bcnt0 !== 32'd0) begin
      fails++; $display("FAIL mrst_release got rv=%b addr=%h bcnt=%0d want 0/0000/0", rv0, addr0, bcnt0);
    end
    run(8);
    tests++;
    if (log0.size() < 1) begin
      fails++; $display("FAIL mrst_count got 0 want >=1");
    end else begin
      tests++; if (log0[0].pc !== 16'h0 || log0[0].cyc - base !== 3 || log0[0].data !== 32'd1) begin
        fails++; $display("FAIL mrst_first got pc=%h at +%0d data=%0d want 0000 at +3 data=1",
                          log0[0].pc, log0[0].cyc - base, log0[0].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_rtype();
    test_branch(6'd4);
    test_branch(6'd5);
    test_r0();
    test_halt();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
